// File: rtl/tmds_pkg.sv
// Shared TMDS definitions, used by both the encoder and the decoder.
//   tmds_word_t     - one 10-bit TMDS symbol, bit 0 first on the wire
//   TMDS_CTRL_xx    - the four control tokens, one per {c1,c0} value
//   tmds_dec_t      - decoded symbol {is_ctrl, ctrl[1:0], data[7:0]}
//   align_state_t   - word-aligner FSM states
//   tmds_is_ctrl()  - control-token match
//   tmds_decode()   - full symbol decode
package tmds_pkg;

    typedef logic [9:0] tmds_word_t;

    localparam tmds_word_t TMDS_CTRL_00 = 10'b1101010100;
    localparam tmds_word_t TMDS_CTRL_01 = 10'b0010101011;
    localparam tmds_word_t TMDS_CTRL_10 = 10'b0101010100;
    localparam tmds_word_t TMDS_CTRL_11 = 10'b1010101011;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] ctrl;
        logic [7:0] data;
    } tmds_dec_t;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_WAIT_SLIP = 2'd1,
        ST_LOCKED    = 2'd2
    } align_state_t;

    function automatic logic tmds_is_ctrl(input tmds_word_t w);
        return (w == TMDS_CTRL_00) || (w == TMDS_CTRL_01) ||
               (w == TMDS_CTRL_10) || (w == TMDS_CTRL_11);
    endfunction

    function automatic tmds_dec_t tmds_decode(input tmds_word_t w);
        tmds_dec_t  r;
        logic [7:0] d;
        r         = '0;
        // bit 9 flags an inverted payload, bit 8 selects XOR vs XNOR chaining
        d         = w[9] ? ~w[7:0] : w[7:0];
        r.data[0] = d[0];
        for (int i = 1; i < 8; i++)
            r.data[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        r.is_ctrl = tmds_is_ctrl(w);
        case (w)
            TMDS_CTRL_01: r.ctrl = 2'b01;
            TMDS_CTRL_10: r.ctrl = 2'b10;
            TMDS_CTRL_11: r.ctrl = 2'b11;
            default:      r.ctrl = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder_aligner.sv
// tmds_word_aligner: word-alignment FSM for one TMDS channel.
//   SEARCH    - look for CTRL_RUN_MIN consecutive tokens; after SEARCH_TIMEOUT
//               cycles without one, pulse o_bitslip and go to WAIT_SLIP.
//   WAIT_SLIP - ignore SLIP_WAIT cycles while the deserializer settles.
//   LOCKED    - drop back to SEARCH after LOCK_TIMEOUT cycles without a token.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_is_ctrl           stage-1 control-token flag
//   o_aligned           1 while LOCKED (registered with the state)
//   o_bitslip           one-cycle rotate request
//   o_lock_loss_count   saturating LOCKED->SEARCH count
//                       (only with TMDS_DEC_LOCK_STATS_EN)
module tmds_word_aligner import tmds_pkg::*; #(
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int CTRL_RUN_MIN   = 8,
    parameter int SLIP_WAIT      = 4,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_is_ctrl,
    output logic        o_aligned,
    output logic        o_bitslip
`ifdef TMDS_DEC_LOCK_STATS_EN
   ,output logic [15:0] o_lock_loss_count
`endif
);

    localparam int TW = $clog2(SEARCH_TIMEOUT);
    localparam int RW = $clog2(CTRL_RUN_MIN + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int IW = $clog2(LOCK_TIMEOUT);

    align_state_t  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          aligned_q, aligned_d;
    logic          bitslip_q, bitslip_d;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        run_cnt_d  = run_cnt_q;
        wait_cnt_d = wait_cnt_q;
        idle_cnt_d = idle_cnt_q;
        bitslip_d  = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                if (!i_is_ctrl)           run_cnt_d = '0;
                else if (run_cnt_q != '1) run_cnt_d = run_cnt_q + 1'b1;
                // lock is checked first so a qualifying run beats the timeout
                if (i_is_ctrl && run_cnt_q == RW'(CTRL_RUN_MIN - 1)) begin
                    state_d    = ST_LOCKED;
                    idle_cnt_d = '0;
                end else if (timer_q == TW'(SEARCH_TIMEOUT - 1)) begin
                    state_d    = ST_WAIT_SLIP;
                    bitslip_d  = 1'b1;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT_SLIP: begin
                if (wait_cnt_q == WW'(SLIP_WAIT - 1)) begin
                    state_d   = ST_SEARCH;
                    timer_d   = '0;
                    run_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (i_is_ctrl) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IW'(LOCK_TIMEOUT - 1)) begin
                    state_d    = ST_SEARCH;
                    idle_cnt_d = '0;
                    timer_d    = '0;
                    run_cnt_d  = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
        aligned_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_SEARCH;
            timer_q    <= '0;
            run_cnt_q  <= '0;
            wait_cnt_q <= '0;
            idle_cnt_q <= '0;
            aligned_q  <= 1'b0;
            bitslip_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            run_cnt_q  <= run_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            aligned_q  <= aligned_d;
            bitslip_q  <= bitslip_d;
        end
    end

    assign o_aligned = aligned_q;
    assign o_bitslip = bitslip_q;

`ifdef TMDS_DEC_LOCK_STATS_EN
    logic [15:0] loss_q, loss_d;

    always_comb begin
        loss_d = loss_q;
        if (state_q == ST_LOCKED && state_d == ST_SEARCH && loss_q != '1)
            loss_d = loss_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) loss_q <= '0;
        else       loss_q <= loss_d;
    end

    assign o_lock_loss_count = loss_q;
`endif

endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: one TMDS receive channel.
// Stage 1 registers the raw word and its token flag (which drives the
// aligner); stage 2 registers the decoded outputs, gated by o_aligned.
// Optional: define TMDS_DEC_LOCK_STATS_EN to add o_lock_loss_count.
// Ports:
//   i_clk, i_rst        pixel clock, synchronous active-high reset
//   i_tmds              10-bit word from the deserializer, bit 0 first
//   o_data              decoded pixel byte (0 on control words)
//   o_control           {c1,c0}; holds across data words
//   o_de                1 = data word, 0 = control token
//   o_aligned           word alignment achieved
//   o_bitslip           one-cycle rotate request to the deserializer
//   o_lock_loss_count   saturating lock-loss count (optional)
module tmds_channel_decoder import tmds_pkg::*; #(
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int CTRL_RUN_MIN   = 8,
    parameter int SLIP_WAIT      = 4,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [9:0]  i_tmds,
    output logic [7:0]  o_data,
    output logic [1:0]  o_control,
    output logic        o_de,
    output logic        o_aligned,
    output logic        o_bitslip
`ifdef TMDS_DEC_LOCK_STATS_EN
   ,output logic [15:0] o_lock_loss_count
`endif
);

    tmds_word_t word_q, word_d;
    logic       s1_ctrl_q, s1_ctrl_d;
    logic [7:0] data_q, data_d;
    logic [1:0] control_q, control_d;
    logic       de_q, de_d;
    tmds_dec_t  s1_dec;

    always_comb begin
        word_d    = i_tmds;
        s1_ctrl_d = tmds_is_ctrl(i_tmds);
    end

    always_comb begin
        s1_dec    = tmds_decode(word_q);
        data_d    = '0;
        control_d = control_q;
        de_d      = 1'b0;
        // o_aligned is already registered, so gating uses the value that was
        // valid while this word sat in stage 1
        if (!o_aligned) begin
            control_d = '0;
        end else if (s1_dec.is_ctrl) begin
            control_d = s1_dec.ctrl;
        end else begin
            de_d   = 1'b1;
            data_d = s1_dec.data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_q    <= '0;
            s1_ctrl_q <= 1'b0;
            data_q    <= '0;
            control_q <= '0;
            de_q      <= 1'b0;
        end else begin
            word_q    <= word_d;
            s1_ctrl_q <= s1_ctrl_d;
            data_q    <= data_d;
            control_q <= control_d;
            de_q      <= de_d;
        end
    end

    assign o_data    = data_q;
    assign o_control = control_q;
    assign o_de      = de_q;

    tmds_word_aligner #(
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .CTRL_RUN_MIN   (CTRL_RUN_MIN),
        .SLIP_WAIT      (SLIP_WAIT),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT)
    ) u_aligner (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_is_ctrl         (s1_ctrl_q),
        .o_aligned         (o_aligned),
        .o_bitslip         (o_bitslip)
`ifdef TMDS_DEC_LOCK_STATS_EN
       ,.o_lock_loss_count (o_lock_loss_count)
`endif
    );

endmodule
